// File: rtl/sms_md_pad.sv
// Mega Drive style gamepad responder for one SMS controller port.
// `define MD_PAD_SIX_BUTTON_EN for the 6-button phase/timeout protocol; otherwise a 3-button pad.
module sms_md_pad #(
  parameter int unsigned TIMEOUT = 80000
) (
  input  logic        MCLK,
  input  logic        RESET,
  input  logic        TH_i,
  input  logic [11:0] BTN,
  output logic [5:0]  PAD_o
);

  logic       th_s1, th_s2, th_s3;
  logic       th_fall;
  logic [2:0] n_next;
  logic [5:0] pad_next;

  // TH is asynchronous to MCLK; th_s3 only exists for edge detection.
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      th_s1 <= 1'b1;
      th_s2 <= 1'b1;
      th_s3 <= 1'b1;
    end else begin
      th_s1 <= TH_i;
      th_s2 <= th_s1;
      th_s3 <= th_s2;
    end
  end

  assign th_fall = th_s3 & ~th_s2;

`ifdef MD_PAD_SIX_BUTTON_EN
  localparam logic [16:0] TO_LAST = 17'(TIMEOUT - 1);

  logic [2:0]  n;
  logic [16:0] to_cnt;

  // A falling edge beats a timeout landing on the same cycle.
  always_comb begin
    n_next = n;
    if (th_fall)
      n_next = (n == 3'd4) ? 3'd1 : n + 3'd1;
    else if (to_cnt == TO_LAST)
      n_next = 3'd0;
  end

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      n      <= 3'd0;
      to_cnt <= 17'd0;
    end else begin
      n <= n_next;
      if (th_fall)
        to_cnt <= 17'd0;
      else if (to_cnt != TO_LAST)
        to_cnt <= to_cnt + 17'd1;
    end
  end
`else
  logic unused_six;

  assign n_next     = 3'd0;
  assign unused_six = ^{BTN[11:8], th_fall};
`endif

  // Order is {TR, TL, D3, D2, D1, D0}, all active-low.
  always_comb begin
    pad_next = {~BTN[6], ~BTN[5], ~BTN[3], ~BTN[2], ~BTN[1], ~BTN[0]};
    if (th_s2) begin
      if (n_next == 3'd3)
        pad_next = {~BTN[6], ~BTN[5], ~BTN[11], ~BTN[8], ~BTN[9], ~BTN[10]};
    end else begin
      case (n_next)
        3'd3:    pad_next = {~BTN[7], ~BTN[4], 4'b0000};
        3'd4:    pad_next = {~BTN[7], ~BTN[4], 4'b1111};
        default: pad_next = {~BTN[7], ~BTN[4], 2'b00, ~BTN[1], ~BTN[0]};
      endcase
    end
  end

  always_ff @(posedge MCLK) begin
    if (RESET)
      PAD_o <= 6'h3f;
    else
      PAD_o <= pad_next;
  end

endmodule

// File: tb/tb_sms_md_pad.sv
// Self-checking bench for sms_md_pad; covers both builds of MD_PAD_SIX_BUTTON_EN.
module tb_sms_md_pad;

  localparam int TO = 32;
`ifdef MD_PAD_SIX_BUTTON_EN
  localparam bit SIX = 1'b1;
`else
  localparam bit SIX = 1'b0;
`endif

  logic        MCLK  = 1'b0;
  logic        RESET = 1'b1;
  logic        TH_i  = 1'b1;
  logic [11:0] BTN   = '0;
  logic [5:0]  PAD_o;

  int tests = 0;
  int fails = 0;
  logic [5:0] exp_q[$];

  typedef struct {
    logic        th;
    logic [11:0] btn;
    logic [5:0]  e3;
    logic [5:0]  e6;
  } vec_t;
  vec_t tbl[11];

  sms_md_pad #(.TIMEOUT(TO)) dut (
    .MCLK (MCLK),
    .RESET(RESET),
    .TH_i (TH_i),
    .BTN  (BTN),
    .PAD_o(PAD_o)
  );

  always #5 MCLK = ~MCLK;

  task automatic steps(input int k);
    repeat (k) begin
      @(posedge MCLK);
      #1;
    end
  endtask

  task automatic check(input string nm);
    logic [5:0] e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s: scoreboard empty, PAD_o=%h", nm, PAD_o);
    end else begin
      e = exp_q.pop_front();
      if (PAD_o !== e) begin
        fails++;
        $display("FAIL %s: PAD_o=%h expected %h", nm, PAD_o, e);
      end
    end
  endtask

  task automatic expect_after(input logic [5:0] v, input int k, input string nm);
    exp_q.push_back(v);
    steps(k);
    check(nm);
  endtask

  task automatic do_reset;
    RESET = 1'b1;
    TH_i  = 1'b1;
    BTN   = '0;
    steps(2);
    RESET = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 12'h000, 6'h3f, 6'h3f};
    tbl[1]  = '{1'b0, 12'h011, 6'h22, 6'h22};
    tbl[2]  = '{1'b1, 12'h0c0, 6'h1f, 6'h1f};
    tbl[3]  = '{1'b0, 12'h0c0, 6'h13, 6'h13};
    tbl[4]  = '{1'b1, 12'h70a, 6'h35, 6'h35};
    tbl[5]  = '{1'b0, 12'h030, 6'h23, 6'h20};
    tbl[6]  = '{1'b1, 12'h900, 6'h3f, 6'h33};
    tbl[7]  = '{1'b0, 12'h024, 6'h33, 6'h3f};
    tbl[8]  = '{1'b1, 12'h024, 6'h2b, 6'h2b};
    tbl[9]  = '{1'b0, 12'h002, 6'h31, 6'h31};
    tbl[10] = '{1'b1, 12'h000, 6'h3f, 6'h3f};

    RESET = 1'b1;
    expect_after(6'h3f, 2, "reset");
    RESET = 1'b0;

    for (int i = 0; i < 11; i++) begin
      TH_i = tbl[i].th;
      BTN  = tbl[i].btn;
      expect_after(SIX ? tbl[i].e6 : tbl[i].e3, 4, $sformatf("vec%0d", i));
    end

    // Latency: BTN one edge, TH three edges.
    do_reset();
    BTN = 12'h011;
    expect_after(6'h3f, 0, "btn_lat0");
    expect_after(6'h3e, 1, "btn_lat1");
    TH_i = 1'b0;
    expect_after(6'h3e, 1, "th_lat1");
    expect_after(6'h3e, 1, "th_lat2");
    expect_after(6'h22, 1, "th_lat3");

    // Reset in the middle of a sequence, TH held low.
    BTN  = '0;
    TH_i = 1'b1; steps(4);
    TH_i = 1'b0; steps(4);
    TH_i = 1'b1; steps(4);
    TH_i = 1'b0;
    expect_after(SIX ? 6'h30 : 6'h33, 4, "pre_rst");
    RESET = 1'b1;
    expect_after(6'h3f, 1, "rst_mid");
    RESET = 1'b0;
    expect_after(6'h33, 3, "post_rst");

`ifdef MD_PAD_SIX_BUTTON_EN
    do_reset();
    for (int p = 0; p < 2; p++) begin
      TH_i = 1'b0; steps(10);
      TH_i = 1'b1; steps(10);
    end
    TH_i = 1'b0;
    expect_after(6'h30, 4, "six_id");
    steps(6);
    BTN  = 12'h100;
    TH_i = 1'b1;
    expect_after(6'h3b, 4, "six_x");
    steps(6);
    TH_i = 1'b0;
    expect_after(6'h3f, 4, "six_n4");

    // Fall one cycle after the timeout fired: phase restarts at 1.
    do_reset();
    TH_i = 1'b0; steps(5);
    TH_i = 1'b1; steps(5);
    TH_i = 1'b0; steps(5);
    TH_i = 1'b1; steps(TO + 1 - 5);
    TH_i = 1'b0;
    expect_after(6'h33, 3, "timeout");

    // Fall on the timeout cycle itself: the edge wins.
    do_reset();
    TH_i = 1'b0; steps(5);
    TH_i = 1'b1; steps(5);
    TH_i = 1'b0; steps(5);
    TH_i = 1'b1; steps(TO - 5);
    TH_i = 1'b0;
    expect_after(6'h30, 3, "edge_win");
    BTN  = 12'h100;
    TH_i = 1'b1;
    expect_after(6'h3b, 3, "cnt_clr");
    expect_after(6'h3b, TO - 8, "hold_n3");
    expect_after(6'h3f, 5, "timeout_n0");
`else
    do_reset();
    for (int p = 0; p < 5; p++) begin
      TH_i = 1'b0;
      expect_after(6'h33, 4, $sformatf("3b_low%0d", p));
      TH_i = 1'b1;
      expect_after(6'h3f, 4, $sformatf("3b_high%0d", p));
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sms_md_pad.md
# sms_md_pad

Controller-side model of a Mega Drive style gamepad, attached to one SMS controller port. It is the responder to the 315-5216 I/O controller. The console drives the TH select line, and this block answers with the active-low button levels on the six port input pins. It follows the 3-button or 6-button select protocol, which includes a TH falling-edge phase counter and an inactivity timeout. It is used in system simulation and in FPGA builds where a USB or keyboard front end supplies the button state.

## Interface
- `TIMEOUT`, default 80000: number of MCLK cycles without a TH falling edge before the phase counter returns to 0 (about 1.5 ms at 53.69 MHz). Legal range is 2 to 131071.
- `MCLK` input, 1 bit: system clock. It is the only clock.
- `RESET` input, 1 bit: synchronous, active-high reset.
- `TH_i` input, 1 bit: select line from the console port. It is asynchronous to MCLK.
- `BTN` input, 12 bits: buttons, active-high when pressed, assumed quasi-static. Bit order is [0] Up, [1] Down, [2] Left, [3] Right, [4] A, [5] B, [6] C, [7] Start, [8] X, [9] Y, [10] Z, [11] Mode.
- `PAD_o` output, 6 bits, registered and active-low (0 means pressed or driven low). Bit order is [0] D0, [1] D1, [2] D2, [3] D3, [4] TL, [5] TR.

## Operation
- TH synchroniser:
  - Two flops, `th_s1` then `th_s2`, both reset to 1.
  - `th_s3` holds the previous value of `th_s2` for edge detection.
  - A falling edge is `th_s3 & ~th_s2`.
- Phase counter `n`:
  - 3 bits, range 0 to 4, reset to 0.
  - On a falling edge: if `n` is 4, `n` becomes 1; otherwise `n` becomes `n` + 1.
- Timeout counter:
  - 17 bits, reset to 0.
  - Cleared on every falling edge; otherwise increments and saturates at `TIMEOUT` − 1.
  - When the counter equals `TIMEOUT` − 1 and there is no falling edge, `n` is set to 0.
  - A falling edge in the same cycle as the timeout wins: `n` advances normally and the counter clears.
- Output mapping, selected by `th_s2` and the `n` value after this cycle's update, then registered into `PAD_o`. Fields are listed as TR, TL, D3, D2, D1, D0:
  - TH=1 and `n` in {0, 1, 2, 4}: ~C, ~B, ~Right, ~Left, ~Down, ~Up.
  - TH=1 and `n`=3: ~C, ~B, ~Mode, ~X, ~Y, ~Z.
  - TH=0 and `n` in {0, 1, 2}: ~Start, ~A, 0, 0, ~Down, ~Up.
  - TH=0 and `n`=3: ~Start, ~A, 0, 0, 0, 0. This is the 6-button identification pattern.
  - TH=0 and `n`=4: ~Start, ~A, 1, 1, 1, 1.
- `BTN` is sampled only by the `PAD_o` register. It has no synchroniser and no debounce.

## Timing
- Reset values:
  - `PAD_o` = 6'h3f.
  - `n` = 0.
  - Timeout counter = 0.
  - `th_s1`, `th_s2` and `th_s3` = 1.
- `RESET` overrides everything on the same MCLK edge. Asserting it in the middle of a sequence returns the block to phase 0.
- Latency from a TH change at the `TH_i` pin to a `PAD_o` update is exactly 3 MCLK edges: two synchroniser stages plus the output register.
- Latency from a `BTN` change to a `PAD_o` update is 1 MCLK edge.
- Rising edges of TH never change `n`.
- The timeout fires `TIMEOUT` cycles after the last falling edge. It then holds `n` at 0 until the next falling edge.

## Configuration
- `MD_PAD_SIX_BUTTON_EN`:
  - Defined: the full 6-button protocol described above, including the phase and timeout counters.
  - Undefined: 3-button pad. The phase and timeout logic is compiled out, and `n` is treated as constantly 0. TH=1 gives ~C, ~B, ~Right, ~Left, ~Down, ~Up; TH=0 gives ~Start, ~A, 0, 0, ~Down, ~Up. The `TIMEOUT` parameter is ignored.

## Test plan
- Reset, `BTN`=0, `TH_i`=1 → `PAD_o`=6'h3f. Then press Up and A (`BTN`=12'h011) and drive `TH_i` to 0. Exactly 3 cycles later `PAD_o`=6'h22, with `n`=1.
- `BTN`=0 and three TH low pulses, each 10 cycles long with 10-cycle gaps. While TH is low on the third pulse, `PAD_o`=6'h30. Press X; on the next TH high, `PAD_o`=6'h3b. On the fourth TH low, `PAD_o`=6'h3f.
- Timeout: give two falling edges, then hold `TH_i`=1 for `TIMEOUT` cycles and drive TH low → `n`=1 and `PAD_o`=6'h33, not the identification pattern 6'h30.
- Edge on the same cycle as the timeout: place a falling edge at timeout counter = `TIMEOUT` − 1 with `n`=2 → `n`=3 and the counter is 0.
- `RESET` pulsed for one cycle while `n`=3 and TH is low → `PAD_o`=6'h3f on the next edge and `n`=0. The following TH low gives 6'h33.
- Build without `MD_PAD_SIX_BUTTON_EN`, run five TH low pulses with `BTN`=0 → every TH low gives `PAD_o`=6'h33 and every TH high gives 6'h3f.
